// File: rtl/oled_pkg.sv
// Shared command codes, decoder states and address helpers for the OLED serial receiver.
package oled_pkg;

  localparam int unsigned AddrW = 7;
  localparam int unsigned PixW  = 16;

  localparam logic [7:0] SetX       = 8'h15;
  localparam logic [7:0] SetY       = 8'h75;
  localparam logic [7:0] SetPixel   = 8'h5C;
  localparam logic [7:0] CmdNormal  = 8'hA6;
  localparam logic [7:0] CmdInverse = 8'hA7;

  typedef enum logic [2:0] {
    StIdle,
    StColStart,
    StColEnd,
    StRowStart,
    StRowEnd,
    StPixHi,
    StPixLo
  } dec_state_e;

  // Limit a window address to the highest legal value.
  function automatic logic [AddrW-1:0] clamp_addr(input logic [AddrW-1:0] v,
                                                  input logic [AddrW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/oled_sdi_shifter.sv
// Serial byte capture: SCLK edge detect, 8-bit shift, nCS abort detection.
module oled_sdi_shifter (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       nCS,
  input  logic       DnC,
  input  logic       SDIN,
  input  logic       SCLK,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dnc,
  output logic       abort_err
);

  logic       sclk_q;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  // Sample bits on SCLK rising edges; deselect discards any partial byte.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sclk_q     <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dnc   <= 1'b0;
      abort_err  <= 1'b0;
    end else begin
      sclk_q     <= SCLK;
      byte_valid <= 1'b0;
      abort_err  <= 1'b0;
      if (nCS) begin
        bit_cnt   <= '0;
        abort_err <= (bit_cnt != 3'd0);
      end else if (SCLK && !sclk_q) begin
        shreg   <= {shreg[5:0], SDIN};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, SDIN};
          byte_dnc   <= DnC;
        end
      end
    end
  end

endmodule

// File: rtl/oled_sdi_receiver.sv
// OLED 4-wire serial receiver: decodes window/pixel/inversion commands into frame-buffer writes.
module oled_sdi_receiver
  import oled_pkg::*;
#(
  parameter int unsigned ColMax   = 127,
  parameter int unsigned RowMax   = 127,
  parameter int unsigned ErrWidth = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                nCS,
  input  logic                DnC,
  input  logic                SDIN,
  input  logic                SCLK,
  output logic                pix_we,
  output logic [AddrW-1:0]    pix_x,
  output logic [AddrW-1:0]    pix_y,
  output logic [PixW-1:0]     pix_data,
  output logic                inverted,
  output logic                frame_done,
  output logic [ErrWidth-1:0] err_count
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dnc;
  logic       abort_err;

  oled_sdi_shifter u_shifter (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .nCS        (nCS),
    .DnC        (DnC),
    .SDIN       (SDIN),
    .SCLK       (SCLK),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dnc   (byte_dnc),
    .abort_err  (abort_err)
  );

  dec_state_e       state_q, state_d;
  logic [AddrW-1:0] col_start, col_end, row_start, row_end;
  logic [AddrW-1:0] cur_x, cur_y;
  logic [7:0]       hi_q;

  logic col_start_we, col_end_we, row_start_we, row_end_we;
  logic hi_we, pix_fire, cur_load, inv_set, inv_clr, dec_err;

  logic [AddrW-1:0] win_col, win_row;
  logic [1:0]       err_inc;
  logic [ErrWidth:0] err_sum;

  assign win_col = clamp_addr(byte_data[6:0], AddrW'(ColMax));
  assign win_row = clamp_addr(byte_data[6:0], AddrW'(RowMax));
  assign err_inc = {1'b0, abort_err} + {1'b0, dec_err};
  assign err_sum = {1'b0, err_count} + (ErrWidth+1)'(err_inc);

  // Decoder state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state: commands override any state, data bytes walk the sequence.
  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      if (!byte_dnc) begin
        case (byte_data)
          SetX:     state_d = StColStart;
          SetY:     state_d = StRowStart;
          SetPixel: state_d = StPixHi;
          default:  state_d = StIdle;
        endcase
      end else begin
        case (state_q)
          StColStart: state_d = StColEnd;
          StRowStart: state_d = StRowEnd;
          StPixHi:    state_d = StPixLo;
          StPixLo:    state_d = StPixHi;
          default:    state_d = StIdle;
        endcase
      end
    end
  end

  // Decoder actions for the byte presented this cycle.
  always_comb begin
    col_start_we = 1'b0;
    col_end_we   = 1'b0;
    row_start_we = 1'b0;
    row_end_we   = 1'b0;
    hi_we        = 1'b0;
    pix_fire     = 1'b0;
    cur_load     = 1'b0;
    inv_set      = 1'b0;
    inv_clr      = 1'b0;
    dec_err      = 1'b0;
    if (byte_valid) begin
      if (!byte_dnc) begin
        case (byte_data)
          SetX, SetY: ;
          SetPixel:   cur_load = 1'b1;
          CmdNormal:  inv_clr  = 1'b1;
          CmdInverse: inv_set  = 1'b1;
          default:    dec_err  = 1'b1;
        endcase
      end else begin
        case (state_q)
          StColStart: col_start_we = 1'b1;
          StColEnd:   col_end_we   = 1'b1;
          StRowStart: row_start_we = 1'b1;
          StRowEnd:   row_end_we   = 1'b1;
          StPixHi:    hi_we        = 1'b1;
          StPixLo:    pix_fire     = 1'b1;
          default:    dec_err      = 1'b1;
        endcase
      end
    end
  end

  // Window registers, raster cursor, pixel outputs and saturating error counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_start  <= '0;
      col_end    <= AddrW'(ColMax);
      row_start  <= '0;
      row_end    <= AddrW'(RowMax);
      cur_x      <= '0;
      cur_y      <= '0;
      hi_q       <= '0;
      pix_we     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      inverted   <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      if (col_start_we) col_start <= win_col;
      if (col_end_we)   col_end   <= (win_col > col_start) ? win_col : col_start;
      if (row_start_we) row_start <= win_row;
      if (row_end_we)   row_end   <= (win_row > row_start) ? win_row : row_start;
      if (hi_we)        hi_q      <= byte_data;
      if (inv_set)      inverted  <= 1'b1;
      if (inv_clr)      inverted  <= 1'b0;
      if (cur_load) begin
        cur_x <= col_start;
        cur_y <= row_start;
      end
      if (pix_fire) begin
        pix_we   <= 1'b1;
        pix_x    <= cur_x;
        pix_y    <= cur_y;
        pix_data <= {hi_q, byte_data};
        if (cur_x == col_end) begin
          cur_x <= col_start;
          if (cur_y == row_end) begin
            cur_y      <= row_start;
            frame_done <= 1'b1;
          end else begin
            cur_y <= cur_y + AddrW'(1);
          end
        end else begin
          cur_x <= cur_x + AddrW'(1);
        end
      end
      if (err_inc != 2'd0) begin
        err_count <= err_sum[ErrWidth] ? '1 : err_sum[ErrWidth-1:0];
      end
    end
  end

endmodule

// File: tb/tb_oled_sdi_receiver.sv
`timescale 1ns/1ps
module tb_oled_sdi_receiver;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        nCS = 1'b1;
  logic        DnC = 1'b0;
  logic        SDIN = 1'b0;
  logic        SCLK = 1'b0;
  logic        pix_we;
  logic [6:0]  pix_x;
  logic [6:0]  pix_y;
  logic [15:0] pix_data;
  logic        inverted;
  logic        frame_done;
  logic [7:0]  err_count;

  always #5 HCLK = ~HCLK;

  oled_sdi_receiver dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .nCS        (nCS),
    .DnC        (DnC),
    .SDIN       (SDIN),
    .SCLK       (SCLK),
    .pix_we     (pix_we),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .inverted   (inverted),
    .frame_done (frame_done),
    .err_count  (err_count)
  );

  typedef struct {
    int x;
    int y;
    int d;
    int fd;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  stray_fd = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model state: window, pixels since last SetPixel, flags.
  int m_cs = 0, m_ce = 127, m_rs = 0, m_re = 127;
  int m_idx = 0;
  int m_err = 0;
  int m_inv = 0;

  // Collect every write the DUT makes, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (pix_we) obs_q.push_back('{int'(pix_x), int'(pix_y), int'(pix_data), int'(frame_done)});
    if (frame_done && !pix_we) stray_fd++;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
    nCS = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge HCLK); SDIN = b[i]; DnC = dc; SCLK = 1'b0;
      @(negedge HCLK);
      @(negedge HCLK); SCLK = 1'b1;
      @(negedge HCLK);
    end
    @(negedge HCLK); SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    send_bits(dc, b, 8);
  endtask

  task automatic deselect();
    @(negedge HCLK); nCS = 1'b1;
    idle(3);
  endtask

  function automatic int sat_err(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  // Program a window edge pair and mirror the clamping/ordering rules in the model.
  task automatic set_window(input logic rows, input logic [7:0] sb, input logic [7:0] eb);
    int s, e;
    send_byte(1'b0, rows ? 8'h75 : 8'h15);
    send_byte(1'b1, sb);
    send_byte(1'b1, eb);
    s = int'(sb & 8'h7F);
    e = int'(eb & 8'h7F);
    if (e < s) e = s;
    if (rows) begin m_rs = s; m_re = e; end
    else      begin m_cs = s; m_ce = e; end
  endtask

  // Stream n pixels; the expected position is derived from the raster index.
  task automatic send_pixels(input int n, input logic rnd, input logic [15:0] fixed);
    int w, h, area;
    logic [15:0] v;
    w = m_ce - m_cs + 1;
    h = m_re - m_rs + 1;
    area = w * h;
    for (int k = 0; k < n; k++) begin
      v = rnd ? 16'($urandom) : fixed;
      send_byte(1'b1, v[15:8]);
      send_byte(1'b1, v[7:0]);
      exp_q.push_back('{m_cs + (m_idx % w), m_rs + ((m_idx / w) % h), int'(v),
                        ((m_idx % area) == area - 1) ? 1 : 0});
      m_idx++;
    end
    idle(4);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_x"}, o.x, e.x);
      chk({tag, "_y"}, o.y, e.y);
      chk({tag, "_data"}, o.d, e.d);
      chk({tag, "_fd"}, o.fd, e.fd);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_inv"}, int'(inverted), m_inv);
    chk({tag, "_err"}, int'(err_count), m_err);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_pix_we", int'(pix_we), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_inv", int'(inverted), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_err", int'(err_count), 0);
    HRESETn = 1'b1;
    idle(3);

    // Window setup: columns 14..21, rows 31..43
    set_window(1'b0, 8'h0E, 8'h15);
    set_window(1'b1, 8'h1F, 8'h2B);
    idle(4);
    chk("win_no_write", obs_q.size(), 0);
    check_flags("win");

    // Full glyph of 104 pixels, frame_done on the last one
    send_byte(1'b0, 8'h5C);
    m_idx = 0;
    send_pixels(104, 1'b0, 16'h063C);
    if (obs_q.size() == 104) begin
      chk("glyph_first_x", obs_q[0].x, 14);
      chk("glyph_first_y", obs_q[0].y, 31);
      chk("glyph_8th_x", obs_q[7].x, 21);
      chk("glyph_9th_xy", obs_q[8].x * 256 + obs_q[8].y, 14 * 256 + 32);
      chk("glyph_last_xy", obs_q[103].x * 256 + obs_q[103].y, 21 * 256 + 43);
      chk("glyph_last_fd", obs_q[103].fd, 1);
      chk("glyph_last_data", obs_q[103].d, 16'h063C);
    end
    compare_writes("glyph");

    // Inversion on and off
    send_byte(1'b0, 8'hA7); m_inv = 1;
    idle(3);
    check_flags("inv_on");
    send_byte(1'b0, 8'hA6); m_inv = 0;
    idle(3);
    check_flags("inv_off");

    // Aborted byte then a full inverse command
    send_bits(1'b0, 8'hA7, 5);
    deselect();
    m_err++;
    send_byte(1'b0, 8'hA7); m_inv = 1;
    idle(3);
    check_flags("abort");

    // Randomized windows (some with end below start) and pixel streams, with frame wrap
    for (int r = 0; r < 3; r++) begin
      logic [7:0] cb, rb, ceb, reb;
      int w, h, n;
      cb  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      ceb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(cb + 8'($urandom_range(0, 3)));
      reb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(rb + 8'($urandom_range(0, 2)));
      set_window(1'b0, cb, ceb);
      set_window(1'b1, rb, reb);
      send_byte(1'b0, 8'h5C);
      m_idx = 0;
      w = m_ce - m_cs + 1;
      h = m_re - m_rs + 1;
      n = w * h + $urandom_range(1, 6);
      if (n > 60) n = 60;
      send_pixels(n, 1'b1, 16'h0000);
      compare_writes("rand");
      check_flags("rand");
      deselect();
    end

    // Bad traffic: data byte in Idle and an unknown command
    send_byte(1'b0, 8'hA6); m_inv = 0;
    send_byte(1'b1, 8'h55); m_err++;
    send_byte(1'b0, 8'hAF); m_err++;
    idle(3);
    check_flags("bad");

    // Error flood saturates the counter
    for (int i = 0; i < 300; i++) begin
      send_byte(1'b1, 8'($urandom_range(0, 255)));
      m_err = sat_err(m_err + 1);
    end
    idle(3);
    check_flags("sat");
    chk("sat_no_write", obs_q.size(), 0);

    // Reset in the middle of a pixel
    send_byte(1'b0, 8'h5C);
    send_byte(1'b1, 8'hF8);
    @(negedge HCLK); HRESETn = 1'b0;
    idle(2);
    chk("mid_rst_we", int'(pix_we), 0);
    chk("mid_rst_data", int'(pix_data), 0);
    chk("mid_rst_xy", int'(pix_x) + int'(pix_y), 0);
    chk("mid_rst_err", int'(err_count), 0);
    chk("mid_rst_inv", int'(inverted), 0);
    m_err = 0; m_inv = 0;
    @(negedge HCLK); HRESETn = 1'b1;
    idle(2);
    send_byte(1'b1, 8'h1F); m_err++;
    idle(4);
    check_flags("post_rst");
    chk("post_rst_no_write", obs_q.size(), 0);
    chk("stray_frame_done", stray_fd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
